// File: rtl/oled_task_arbiter.sv
// rtl/oled_task_arbiter.sv - frame-aligned OLED pixel-stream arbiter for four tasks plus default renderer
module oled_task_arbiter #(
  parameter logic [15:0] CODE_A        = 16'b0001_0000_0001_1001,
  parameter logic [15:0] CODE_B        = 16'b0010_0011_0000_1011,
  parameter logic [15:0] CODE_C        = 16'b0100_0010_0010_1011,
  parameter logic [15:0] CODE_D        = 16'b1000_0011_0001_1001,
  parameter int          STABLE_CYCLES = 62500,
  parameter int          RESET_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        frame_begin,
  input  logic [15:0] data_t0,
  input  logic [15:0] data_t1,
  input  logic [15:0] data_t2,
  input  logic [15:0] data_t3,
  input  logic [15:0] data_t4,
  output logic [15:0] oled_data,
  output logic [2:0]  active_task,
  output logic [3:0]  task_reset,
  output logic        switching
);

  localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST   = HCW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {RUN, WAIT_FRAME, HOLD, SYNC} state_t;

  state_t         state;
  logic [2:0]     raw_code;
  logic [2:0]     candidate;
  logic [2:0]     stable_code;
  logic [SCW-1:0] cnt;
  logic [HCW-1:0] hcnt;
  logic [15:0]    owner_data;

  // All tasks held in reset except the current owner (none for the default renderer).
  function automatic logic [3:0] reset_mask(input logic [2:0] owner);
    logic [3:0] m;
    m = 4'b1111;
    if (owner != 3'd0) m[2'(owner - 3'd1)] = 1'b0;
    return m;
  endfunction

  // Switch pattern decode; the if-chain order makes the lowest index win on overlap.
  always_comb begin
    raw_code = 3'd0;
    if      (sw == CODE_A) raw_code = 3'd1;
    else if (sw == CODE_B) raw_code = 3'd2;
    else if (sw == CODE_C) raw_code = 3'd3;
    else if (sw == CODE_D) raw_code = 3'd4;
  end

  // Pixel source of the current owner.
  always_comb begin
    case (active_task)
      3'd1:    owner_data = data_t1;
      3'd2:    owner_data = data_t2;
      3'd3:    owner_data = data_t3;
      3'd4:    owner_data = data_t4;
      default: owner_data = data_t0;
    endcase
  end

  // Debounce: a decoded code must persist with a saturating counter before it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      candidate   <= 3'd0;
      cnt         <= '0;
      stable_code <= 3'd0;
    end else if (raw_code != candidate) begin
      candidate <= raw_code;
      cnt       <= '0;
    end else if (cnt == STABLE_LAST) begin
      stable_code <= candidate;
    end else begin
      cnt <= cnt + SCW'(1);
    end
  end

  // Ownership FSM: handovers wait for a frame boundary, hold the new task in reset,
  // then blank until the next frame boundary so the incoming task starts on a whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      oled_data   <= 16'h0000;
      active_task <= 3'd0;
      task_reset  <= 4'b1111;
      switching   <= 1'b0;
      hcnt        <= '0;
    end else begin
      case (state)
        RUN: begin
          oled_data  <= owner_data;
          task_reset <= reset_mask(active_task);
          switching  <= 1'b0;
          if (stable_code != active_task) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (stable_code == active_task) begin
            oled_data <= owner_data;
            state     <= RUN;
          end else if (frame_begin) begin
            // The target follows stable_code right up to the boundary.
            active_task <= stable_code;
            task_reset  <= 4'b1111;
            oled_data   <= 16'h0000;
            hcnt        <= '0;
            switching   <= 1'b1;
            state       <= HOLD;
          end else begin
            oled_data <= owner_data;
          end
        end
        HOLD: begin
          oled_data <= 16'h0000;
          if (hcnt == HOLD_LAST) begin
            task_reset <= reset_mask(active_task);
            state      <= SYNC;
          end else begin
            hcnt <= hcnt + HCW'(1);
          end
        end
        SYNC: begin
          if (frame_begin) begin
            oled_data <= owner_data;
            switching <= 1'b0;
            state     <= RUN;
          end else begin
            oled_data <= 16'h0000;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/oled_task_arbiter.md
Name: oled_task_arbiter

Overview:
Arbitrates the shared 96x64 OLED pixel stream among four sub-task renderers and the default-number renderer. It decodes the 16-bit switch pattern into a task request and debounces it. Ownership changes only at frame boundaries, so no frame is torn. Each task's reset is sequenced so an incoming task always starts from a clean state. It sits between the task renderers and the Oled_Display pixel_data input, on the 6.25 MHz pixel clock.

Parameters:
CODE_A, 16'b0001_0000_0001_1001, switch pattern selecting task 1
CODE_B, 16'b0010_0011_0000_1011, switch pattern selecting task 2
CODE_C, 16'b0100_0010_0010_1011, switch pattern selecting task 3
CODE_D, 16'b1000_0011_0001_1001, switch pattern selecting task 4
STABLE_CYCLES, 62500, consecutive cycles a decoded code must hold before acceptance (10 ms at 6.25 MHz); minimum 1
RESET_CYCLES, 16, cycles the incoming task is held in reset after a switch; minimum 1

Ports:
clk  in  1  6.25 MHz pixel clock
reset  in  1  synchronous, active-high
sw  in  16  raw slide switches
frame_begin  in  1  one-cycle pulse from Oled_Display at start of frame
data_t0  in  16  RGB565 pixel from default renderer
data_t1..data_t4  in  16 each  RGB565 pixel from tasks 1..4
oled_data  out  16  registered pixel to Oled_Display
active_task  out  3  current owner: 0=default, 1..4=task
task_reset  out  4  bit i high holds task i+1 in reset
switching  out  1  high while a handover is in progress (HOLD or SYNC)

Behaviour:
- Reset values: oled_data=16'h0000, active_task=0, task_reset=4'b1111, switching=0, state=RUN, stable_code=0, candidate=0, counter=0.
- Decode: raw=1..4 on an exact match with CODE_A..D, else 0. On multiple matches, the lowest index wins.
- Debounce:
  - If raw!=candidate: candidate<=raw, cnt<=0.
  - Else if cnt==STABLE_CYCLES-1: stable_code<=candidate.
  - Else: cnt++.
  - The counter saturates; stable_code never updates from a glitch shorter than STABLE_CYCLES.
- FSM states: RUN, WAIT_FRAME, HOLD, SYNC.
- RUN:
  - oled_data <= data_t[active_task], 1-cycle latency.
  - task_reset = all ones except bit active_task-1 (if active_task!=0).
  - If stable_code!=active_task: target<=stable_code, go to WAIT_FRAME. A frame_begin in that same cycle is ignored.
- WAIT_FRAME:
  - The outgoing owner keeps displaying.
  - If stable_code changes: target tracks it.
  - If stable_code==active_task: return to RUN (cancel), with no reset and no blank.
  - On frame_begin: active_task<=target, task_reset<=4'b1111, oled_data<=0, hcnt<=0, go to HOLD.
- HOLD:
  - oled_data=0, switching=1, all tasks in reset.
  - After RESET_CYCLES cycles, release the reset bit of active_task (if nonzero) and go to SYNC.
- SYNC:
  - oled_data=0, switching=1.
  - On frame_begin: go to RUN. The first task pixel appears on the cycle after that frame_begin.
  - Result: exactly one full frame is black or partial-black between owners.
- Request changes during HOLD or SYNC are not acted on until RUN is re-entered. RUN then sees the mismatch and starts a new handover.
- Target 0 (default): no task reset bit is released, and data_t0 is displayed in RUN.
- Reset asserted mid-handover: returns immediately to reset values. The switch code must then re-qualify for the full STABLE_CYCLES.
- active_task changes only on a frame_begin cycle. task_reset has at most one bit low at any time.

Test Plan (STABLE_CYCLES=4, RESET_CYCLES=3, frame_begin every 100 cycles):
1. Reset released with sw=CODE_A and held. stable_code=1 after 4 cycles. active_task=1 on the next frame_begin. task_reset=4'b1110 is seen 3 cycles later. data_t1 appears on oled_data one cycle after the following frame_begin, with zeros in between.
2. sw=CODE_B pulsed for 3 cycles, then back to CODE_A, while owner is task 1. stable_code stays 1, no state change, and task_reset stays 4'b1110.
3. Owner is task 2 and sw moves to all-zero. At frame_begin: active_task=0 and task_reset=4'b1111. After SYNC, oled_data equals data_t0 (white bars at x 40-45 / 60-65).
4. In WAIT_FRAME toward task 3, sw returns to the current owner's code before frame_begin. Returns to RUN, active_task unchanged, no blank frame, switching never asserted.
5. stable_code changes in the same cycle as frame_begin while in RUN. The handover occurs at the next frame_begin, not the current one.
6. reset asserted during HOLD. The next cycle shows all outputs at reset values, and the sw code needs 4 more cycles to re-qualify.
